// File: rtl/dprs_wctl_if.sv
// Write-side bundle of the dual-port RAM controller: clear engine, CPU
// single-write port, streaming loader and the RAM write port (a2/d2/w2).
interface dprs_wctl_if #(
   parameter int AW = 14
);
   logic          clr;
   logic [7:0]    clrv;
   logic          busy;

   logic          cpu_req;
   logic [AW-1:0] cpu_a;
   logic [7:0]    cpu_d;
   logic          cpu_ack;

   logic          ld_start;
   logic [AW-1:0] ld_base;
   logic          ld_valid;
   logic [7:0]    ld_d;
   logic          ld_ready;
   logic [AW-1:0] ld_a;

   logic [AW-1:0] a2;
   logic [7:0]    d2;
   logic          w2;

   modport master (
      output clr, clrv, cpu_req, cpu_a, cpu_d, ld_start, ld_base, ld_valid, ld_d,
      input  busy, cpu_ack, ld_ready, ld_a, a2, d2, w2
   );

   modport slave (
      input  clr, clrv, cpu_req, cpu_a, cpu_d, ld_start, ld_base, ld_valid, ld_d,
      output busy, cpu_ack, ld_ready, ld_a, a2, d2, w2
   );
endinterface

// File: rtl/dprs_wctl.sv
// Write-port controller for the dual-port RAM: clear engine, CPU writes and loader stream.
// Define DPRS_WCTL_RR_EN for round-robin CPU/loader arbitration (default: CPU wins ties).
module dprs_wctl #(
   parameter int KB = 16
) (
   input  logic         clock,
   input  logic         reset,
   dprs_wctl_if.slave   bus
);
   localparam int N  = KB * 1024;
   localparam int AW = $clog2(N);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t        state;
   logic [AW-1:0] cnt;
   logic [7:0]    clr_val;
   logic [AW-1:0] ld_ptr;
   logic [AW-1:0] ld_next_base;
   logic [AW-1:0] a2_q;
   logic [7:0]    d2_q;
   logic          w2_q;
   logic          ack_q;

   logic          cpu_cand;
   logic          ld_cand;
   logic          cpu_win;
   logic          ld_win;
   logic          arb_open;
   logic          cpu_grant;
   logic          ld_grant;

`ifdef DPRS_WCTL_RR_EN
   logic          last_cpu;
`endif

   // A request that was acked this cycle must not be granted again; the ack gap enforces that.
   always_comb begin
      cpu_cand = bus.cpu_req & ~ack_q;
      ld_cand  = bus.ld_valid;
`ifdef DPRS_WCTL_RR_EN
      if (cpu_cand && ld_cand) begin
         cpu_win = ~last_cpu;
         ld_win  = last_cpu;
      end else begin
         cpu_win = cpu_cand;
         ld_win  = ld_cand;
      end
`else
      cpu_win = cpu_cand;
      ld_win  = ld_cand & ~cpu_cand;
`endif
   end

   assign arb_open     = (state == IDLE) && !bus.clr;
   assign cpu_grant    = arb_open & cpu_win;
   assign ld_grant     = arb_open & ld_win;
   assign ld_next_base = bus.ld_start ? bus.ld_base : ld_ptr;

   assign bus.ld_ready = ld_grant;
   assign bus.busy     = (state == CLEAR);
   assign bus.ld_a     = ld_ptr;
   assign bus.a2       = a2_q;
   assign bus.d2       = d2_q;
   assign bus.w2       = w2_q;
   assign bus.cpu_ack  = ack_q;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state   <= IDLE;
         cnt     <= '0;
         clr_val <= '0;
         ld_ptr  <= '0;
         a2_q    <= '0;
         d2_q    <= '0;
         w2_q    <= 1'b0;
         ack_q   <= 1'b0;
`ifdef DPRS_WCTL_RR_EN
         last_cpu <= 1'b0;
`endif
      end else begin
         w2_q  <= 1'b0;
         ack_q <= 1'b0;

         // ld_start may coincide with a transfer; the byte then lands at ld_base.
         if (ld_grant) begin
            ld_ptr <= ld_next_base + AW'(1);
         end else begin
            ld_ptr <= ld_next_base;
         end

         case (state)
            IDLE: begin
               if (bus.clr) begin
                  state   <= CLEAR;
                  clr_val <= bus.clrv;
                  cnt     <= '0;
               end else if (cpu_grant) begin
                  w2_q  <= 1'b1;
                  a2_q  <= bus.cpu_a;
                  d2_q  <= bus.cpu_d;
                  ack_q <= 1'b1;
`ifdef DPRS_WCTL_RR_EN
                  last_cpu <= 1'b1;
`endif
               end else if (ld_grant) begin
                  w2_q <= 1'b1;
                  a2_q <= ld_next_base;
                  d2_q <= bus.ld_d;
`ifdef DPRS_WCTL_RR_EN
                  last_cpu <= 1'b0;
`endif
               end
            end
            CLEAR: begin
               w2_q <= 1'b1;
               a2_q <= cnt;
               d2_q <= clr_val;
               cnt  <= cnt + AW'(1);
               if (cnt == AW'(N - 1)) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dprs_wctl.sv
// Self-checking bench for dprs_wctl (KB=1): directed scenarios plus a randomized
// CPU/loader run against a behavioural model of the arbitration rules.
module tb_dprs_wctl;
   localparam int KB = 1;
   localparam int N  = 1024;
   localparam int AW = 10;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;
   logic [7:0] mem [N];

   dprs_wctl_if #(.AW(AW)) bus ();

   dprs_wctl #(.KB(KB)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   task automatic idle_inputs();
      bus.clr      = 1'b0;
      bus.clrv     = 8'h00;
      bus.cpu_req  = 1'b0;
      bus.cpu_a    = '0;
      bus.cpu_d    = 8'h00;
      bus.ld_start = 1'b0;
      bus.ld_base  = '0;
      bus.ld_valid = 1'b0;
      bus.ld_d     = 8'h00;
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      next_cycle();
      next_cycle();
      @(negedge clock);
      vectors++;
      if ({bus.w2, bus.cpu_ack, bus.busy} !== 3'b000) begin
         miscompares++;
         $display("[TB] FAIL reset_ctl: got w2/ack/busy=%b expected 000", {bus.w2, bus.cpu_ack, bus.busy});
      end
      vectors++;
      if ({bus.a2, bus.d2, bus.ld_a} !== '0) begin
         miscompares++;
         $display("[TB] FAIL reset_data: got a2=%h d2=%h ld_a=%h expected 0", bus.a2, bus.d2, bus.ld_a);
      end
      next_cycle();
      reset = 1'b1;
      next_cycle();
   endtask

   task automatic test_clear();
      int busy_cyc = 0;
      int writes = 0;
      int order_err = 0;
      int first_busy = -1;
      for (int k = 0; k < N; k++) mem[k] = 8'h00;
      bus.clr  = 1'b1;
      bus.clrv = 8'hA5;
      for (int c = 0; c < 1040; c++) begin
         @(negedge clock);
         if (bus.busy) begin
            busy_cyc++;
            if (first_busy < 0) first_busy = c;
         end
         if (bus.w2) begin
            if (bus.a2 !== AW'(writes) || bus.d2 !== 8'hA5) order_err++;
            mem[bus.a2] = bus.d2;
            writes++;
         end
         next_cycle();
         bus.clr = 1'b0;
      end
      vectors++;
      if (busy_cyc != N) begin
         miscompares++;
         $display("[TB] FAIL clear_busy_cycles: got %0d expected %0d", busy_cyc, N);
      end
      vectors++;
      if (first_busy != 1) begin
         miscompares++;
         $display("[TB] FAIL clear_busy_start: got cycle %0d expected 1", first_busy);
      end
      vectors++;
      if (writes != N || order_err != 0) begin
         miscompares++;
         $display("[TB] FAIL clear_writes: got %0d writes, %0d out of order, expected %0d, 0", writes, order_err, N);
      end
      vectors++;
      if ({mem[0], mem[10'h1FF], mem[10'h3FF]} !== 24'hA5A5A5) begin
         miscompares++;
         $display("[TB] FAIL clear_readback: got %h %h %h expected a5 a5 a5", mem[0], mem[10'h1FF], mem[10'h3FF]);
      end
   endtask

   task automatic test_cpu_write();
      int extra = 0;
      bus.cpu_req = 1'b1;
      bus.cpu_a   = 10'h123;
      bus.cpu_d   = 8'h5C;
      @(negedge clock);
      vectors++;
      if ({bus.w2, bus.cpu_ack} !== 2'b00) begin
         miscompares++;
         $display("[TB] FAIL cpu_pre: got w2/ack=%b expected 00", {bus.w2, bus.cpu_ack});
      end
      next_cycle();
      bus.cpu_req = 1'b0;
      @(negedge clock);
      vectors++;
      if ({bus.w2, bus.cpu_ack, bus.a2, bus.d2} !== {1'b1, 1'b1, 10'h123, 8'h5C}) begin
         miscompares++;
         $display("[TB] FAIL cpu_write: got w2=%b ack=%b a2=%h d2=%h expected 1 1 123 5c", bus.w2, bus.cpu_ack, bus.a2, bus.d2);
      end
      for (int c = 0; c < 3; c++) begin
         next_cycle();
         @(negedge clock);
         if (bus.w2 || bus.cpu_ack) extra++;
      end
      vectors++;
      if (extra != 0) begin
         miscompares++;
         $display("[TB] FAIL cpu_single: got %0d extra write/ack cycles expected 0", extra);
      end
      next_cycle();
   endtask

   task automatic test_loader_wrap();
      logic [AW-1:0] ea;
      logic [7:0]    ed;
      bus.ld_start = 1'b1;
      bus.ld_base  = 10'h3FE;
      next_cycle();
      bus.ld_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.ld_valid = (i < 3);
         bus.ld_d     = 8'(8'h11 * (i + 1));
         @(negedge clock);
         if (i < 3) begin
            vectors++;
            if (bus.ld_ready !== 1'b1) begin
               miscompares++;
               $display("[TB] FAIL ld_ready_%0d: got %b expected 1", i, bus.ld_ready);
            end
         end
         if (i > 0) begin
            ea = 10'h3FE + AW'(i - 1);
            ed = 8'(8'h11 * i);
            vectors++;
            if ({bus.w2, bus.cpu_ack, bus.a2, bus.d2} !== {1'b1, 1'b0, ea, ed}) begin
               miscompares++;
               $display("[TB] FAIL ld_write_%0d: got w2=%b a2=%h d2=%h expected 1 %h %h", i - 1, bus.w2, bus.a2, bus.d2, ea, ed);
            end
         end
         next_cycle();
      end
      bus.ld_valid = 1'b0;
      vectors++;
      if (bus.ld_a !== 10'h001) begin
         miscompares++;
         $display("[TB] FAIL ld_ptr_wrap: got %h expected 001", bus.ld_a);
      end
   endtask

   task automatic test_contention();
      logic [AW-1:0] lp = 10'h001;
      logic [AW-1:0] ea;
      logic [7:0]    ed;
      logic          eack;
      for (int i = 0; i < 7; i++) begin
         bus.cpu_req  = (i < 6);
         bus.ld_valid = (i < 6);
         bus.cpu_a    = 10'h040 + AW'(i);
         bus.cpu_d    = 8'hC0 + 8'(i);
         bus.ld_d     = 8'h80 + 8'(i);
         @(negedge clock);
         if (i < 6) begin
            vectors++;
            if (bus.ld_ready !== ((i % 2) == 1)) begin
               miscompares++;
               $display("[TB] FAIL cont_ready_%0d: got %b expected %b", i, bus.ld_ready, (i % 2) == 1);
            end
         end
         if (i > 0) begin
            if (((i - 1) % 2) == 0) begin
               eack = 1'b1;
               ea   = 10'h040 + AW'(i - 1);
               ed   = 8'hC0 + 8'(i - 1);
            end else begin
               eack = 1'b0;
               ea   = lp;
               ed   = 8'h80 + 8'(i - 1);
               lp   = lp + AW'(1);
            end
            vectors++;
            if ({bus.w2, bus.cpu_ack, bus.a2, bus.d2} !== {1'b1, eack, ea, ed}) begin
               miscompares++;
               $display("[TB] FAIL cont_grant_%0d: got w2=%b ack=%b a2=%h d2=%h expected 1 %b %h %h",
                        i - 1, bus.w2, bus.cpu_ack, bus.a2, bus.d2, eack, ea, ed);
            end
         end
         next_cycle();
      end
      idle_inputs();
   endtask

   task automatic test_clear_preempt();
      int  held_err = 0;
      int  clear_err = 0;
      int  writes = 0;
      bit  cpu_acked = 0;
      bit  ld_taken = 0;
      logic [AW+16-1:0] post_w [2];
      post_w[0] = '0;
      post_w[1] = '0;
      bus.clr      = 1'b1;
      bus.clrv     = 8'h3C;
      bus.cpu_req  = 1'b1;
      bus.cpu_a    = 10'h055;
      bus.cpu_d    = 8'h77;
      bus.ld_start = 1'b1;
      bus.ld_base  = 10'h200;
      bus.ld_valid = 1'b1;
      bus.ld_d     = 8'h99;
      for (int c = 0; c < 1035; c++) begin
         if (c > 0) begin
            bus.clr      = 1'b0;
            bus.ld_start = 1'b0;
            bus.cpu_req  = !cpu_acked;
            bus.ld_valid = !ld_taken;
         end
         @(negedge clock);
         if ((bus.busy || c == 0) && (bus.ld_ready || bus.cpu_ack)) held_err++;
         if (bus.cpu_ack) cpu_acked = 1;
         if (bus.ld_ready && bus.ld_valid) ld_taken = 1;
         if (bus.w2) begin
            if (writes < N) begin
               if (bus.a2 !== AW'(writes) || bus.d2 !== 8'h3C || bus.cpu_ack) clear_err++;
            end else if (writes < N + 2) begin
               post_w[writes - N] = {bus.cpu_ack, bus.w2, 4'h0, bus.a2, bus.d2};
            end
            writes++;
         end
         next_cycle();
      end
      idle_inputs();
      vectors++;
      if (held_err != 0) begin
         miscompares++;
         $display("[TB] FAIL preempt_held: got %0d grant cycles during clear expected 0", held_err);
      end
      vectors++;
      if (clear_err != 0 || writes != N + 2) begin
         miscompares++;
         $display("[TB] FAIL preempt_writes: got %0d writes, %0d bad clear writes, expected %0d, 0", writes, clear_err, N + 2);
      end
      vectors++;
      if (post_w[0] !== {1'b1, 1'b1, 4'h0, 10'h055, 8'h77}) begin
         miscompares++;
         $display("[TB] FAIL preempt_cpu: got %h expected %h", post_w[0], {1'b1, 1'b1, 4'h0, 10'h055, 8'h77});
      end
      vectors++;
      if (post_w[1] !== {1'b0, 1'b1, 4'h0, 10'h200, 8'h99}) begin
         miscompares++;
         $display("[TB] FAIL preempt_ld: got %h expected %h", post_w[1], {1'b0, 1'b1, 4'h0, 10'h200, 8'h99});
      end
   endtask

   task automatic test_reset_mid_clear();
      int stray = 0;
      bus.clr  = 1'b1;
      bus.clrv = 8'hE7;
      next_cycle();
      bus.clr = 1'b0;
      for (int c = 1; c < 100; c++) next_cycle();
      reset = 1'b0;
      @(negedge clock);
      vectors++;
      if (bus.busy !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL midclr_busy_before: got %b expected 1", bus.busy);
      end
      next_cycle();
      reset = 1'b1;
      @(negedge clock);
      vectors++;
      if ({bus.busy, bus.w2, bus.a2, bus.d2} !== '0) begin
         miscompares++;
         $display("[TB] FAIL midclr_abort: got busy=%b w2=%b a2=%h d2=%h expected 0 0 000 00", bus.busy, bus.w2, bus.a2, bus.d2);
      end
      for (int c = 0; c < 20; c++) begin
         next_cycle();
         @(negedge clock);
         if (bus.w2 || bus.busy) stray++;
      end
      vectors++;
      if (stray != 0) begin
         miscompares++;
         $display("[TB] FAIL midclr_stray: got %0d write/busy cycles expected 0", stray);
      end
      next_cycle();
   endtask

   task automatic test_random();
      logic          m_w = 1'b0;
      logic          m_ack = 1'b0;
      logic          m_last_cpu = 1'b0;
      logic [AW-1:0] m_a = '0;
      logic [7:0]    m_d = 8'h00;
      logic [AW-1:0] m_lda = '0;
      logic [AW-1:0] base;
      bit            req_active = 0;
      bit            cpu_c, ld_c, cpu_wins, ld_wins;
      idle_inputs();
      reset = 1'b0;
      next_cycle();
      reset = 1'b1;
      for (int c = 0; c < 600; c++) begin
         if (req_active && m_ack) req_active = 0;
         if (!req_active && ($urandom_range(1, 0) == 1)) begin
            req_active  = 1;
            bus.cpu_a   = AW'($urandom);
            bus.cpu_d   = 8'($urandom);
         end
         bus.cpu_req  = req_active;
         bus.ld_valid = ($urandom_range(2, 0) != 0);
         bus.ld_d     = 8'($urandom);
         bus.ld_start = ($urandom_range(15, 0) == 0);
         bus.ld_base  = AW'($urandom);

         cpu_c = req_active && !m_ack;
         ld_c  = bus.ld_valid;
`ifdef DPRS_WCTL_RR_EN
         if (cpu_c && ld_c) begin
            cpu_wins = !m_last_cpu;
            ld_wins  = m_last_cpu;
         end else begin
            cpu_wins = cpu_c;
            ld_wins  = ld_c;
         end
`else
         cpu_wins = cpu_c;
         ld_wins  = ld_c && !cpu_c;
`endif

         @(negedge clock);
         vectors++;
         if ({bus.w2, bus.cpu_ack, bus.a2, bus.d2} !== {m_w, m_ack, m_a, m_d}) begin
            miscompares++;
            $display("[TB] FAIL rand_write_%0d: got w2=%b ack=%b a2=%h d2=%h expected %b %b %h %h",
                     c, bus.w2, bus.cpu_ack, bus.a2, bus.d2, m_w, m_ack, m_a, m_d);
         end
         vectors++;
         if ({bus.ld_ready, bus.ld_a, bus.busy} !== {ld_wins, m_lda, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL rand_loader_%0d: got ready=%b ld_a=%h busy=%b expected %b %h 0",
                     c, bus.ld_ready, bus.ld_a, bus.busy, ld_wins, m_lda);
         end

         base  = bus.ld_start ? bus.ld_base : m_lda;
         m_w   = 1'b0;
         m_ack = 1'b0;
         m_lda = base;
         if (cpu_wins) begin
            m_w        = 1'b1;
            m_ack      = 1'b1;
            m_a        = bus.cpu_a;
            m_d        = bus.cpu_d;
            m_last_cpu = 1'b1;
         end else if (ld_wins) begin
            m_w        = 1'b1;
            m_a        = base;
            m_d        = bus.ld_d;
            m_lda      = base + AW'(1);
            m_last_cpu = 1'b0;
         end
         next_cycle();
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      reset = 1'b0;
      next_cycle();
      test_reset();
      test_clear();
      test_cpu_write();
      test_loader_wrap();
      test_contention();
      test_clear_preempt();
      test_reset_mid_clear();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
